message_printer: RTL and testbench

// - Sequencer between the 14-byte message ROM and the serial transmitter.
// - Waits for a trigger byte from the serial receiver, then reads the ROM at addresses 0..MSG_LEN-1.
// - Hands each byte to the UART TX with a one-cycle new_tx_data strobe, honouring tx_busy and tx_block.
// - The ROM sits beside this block, not inside it: rom_addr is an output, rom_data an input (1-cycle registered read).

---
 rtl/message_printer_pkg.sv | 15 +
 rtl/message_printer_if.sv | 28 ++
 rtl/message_printer.sv | 81 ++++++++
 tb/tb_message_printer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/message_printer_pkg.sv
// Shared types and default parameters for the message sequencer that feeds
// ROM bytes to the UART transmitter.
package message_printer_pkg;

  localparam int             MSG_LEN_DEFAULT      = 14;
  localparam int             ADDR_W_DEFAULT       = 4;
  localparam logic [7:0]     TRIGGER_CHAR_DEFAULT = 8'h68;  // "h"

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/message_printer_if.sv
// Bundle of receiver, transmitter, ROM and status signals around the printer.
// master = the printer itself; slave = the surrounding UART/ROM environment.
interface message_printer_if #(
  parameter int ADDR_W = 4
) ();

  logic [7:0]        rx_data;
  logic              new_rx_data;
  logic              tx_busy;
  logic              tx_block;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_data;
  logic              new_tx_data;
  logic              busy;
  logic              msg_done;

  modport master (
    input  rx_data, new_rx_data, tx_busy, tx_block, rom_data,
    output rom_addr, tx_data, new_tx_data, busy, msg_done
  );

  modport slave (
    output rx_data, new_rx_data, tx_busy, tx_block, rom_data,
    input  rom_addr, tx_data, new_tx_data, busy, msg_done
  );

endinterface

// File: rtl/message_printer.sv
// Waits for the trigger byte, then walks the external ROM from address 0 to
// MSG_LEN-1, strobing each byte into the transmitter when it is free.
module message_printer
  import message_printer_pkg::*;
#(
  parameter int         MSG_LEN      = MSG_LEN_DEFAULT,
  parameter int         ADDR_W       = ADDR_W_DEFAULT,
  parameter logic [7:0] TRIGGER_CHAR = TRIGGER_CHAR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  message_printer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  state_t            state_reg,   state_next;
  logic [ADDR_W-1:0] addr_reg,    addr_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              new_tx_reg,  new_tx_next;
  logic              done_reg,    done_next;

  logic tx_stalled;
  assign tx_stalled = bus.tx_busy | bus.tx_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      tx_data_reg <= 8'h00;
      new_tx_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      tx_data_reg <= tx_data_next;
      new_tx_reg  <= new_tx_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    tx_data_next = tx_data_reg;
    new_tx_next  = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        addr_next = '0;
        if (bus.new_rx_data && (bus.rx_data == TRIGGER_CHAR)) begin
          state_next = FETCH;
        end
      end
      // One cycle for the ROM read and for tx_busy to rise after a strobe.
      FETCH: state_next = SEND;
      SEND: begin
        if (!tx_stalled) begin
          tx_data_next = bus.rom_data;
          new_tx_next  = 1'b1;
          if (addr_reg == LAST_ADDR) begin
            done_next  = 1'b1;
            addr_next  = '0;
            state_next = IDLE;
          end else begin
            addr_next  = addr_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.rom_addr    = addr_reg;
  assign bus.tx_data     = tx_data_reg;
  assign bus.new_tx_data = new_tx_reg;
  assign bus.msg_done    = done_reg;
  assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_message_printer.sv
// Randomised and directed checks of message_printer against a byte-level
// reference model; the ROM beside the DUT is modelled here.
module tb_message_printer;

  localparam int MSG_LEN = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  message_printer_if #(.ADDR_W(4)) bus ();

  message_printer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [8*MSG_LEN-1:0] msg_bits = "Hello World!\n\r";

  function automatic logic [7:0] msg_byte(input int i);
    return msg_bits[8*(MSG_LEN-1-i) +: 8];
  endfunction

  // External ROM with registered read; addresses past the message read 0.
  logic [7:0] rom_mem [16];
  initial for (int i = 0; i < 16; i++) rom_mem[i] = (i < MSG_LEN) ? msg_byte(i) : 8'h00;
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the message plus a "ROM not yet ready" flag.
  bit         m_active;
  int         m_idx;
  bit         m_wait;
  logic [7:0] exp_tx_data;
  bit         exp_new_tx;
  bit         exp_done;

  // Flow-control drive mode: 0 = tx idle, 1 = busy 10 clks after each strobe, 2 = random.
  int         busy_mode = 0;
  int         hold_cnt  = 0;
  logic       block_var = 1'b0;
  logic [7:0] got [$];

  task automatic model_step(input logic r, input logic rv, input logic [7:0] rd,
                            input logic tbusy, input logic tblock);
    exp_new_tx = 1'b0;
    exp_done   = 1'b0;
    if (r) begin
      m_active    = 1'b0;
      m_idx       = 0;
      m_wait      = 1'b0;
      exp_tx_data = 8'h00;
    end else if (!m_active) begin
      if (rv && rd == "h") begin
        m_active = 1'b1;
        m_idx    = 0;
        m_wait   = 1'b1;
      end
    end else if (m_wait) begin
      m_wait = 1'b0;
    end else if (!(tbusy || tblock)) begin
      exp_new_tx  = 1'b1;
      exp_tx_data = msg_byte(m_idx);
      if (m_idx == MSG_LEN - 1) begin
        exp_done = 1'b1;
        m_active = 1'b0;
        m_idx    = 0;
      end else begin
        m_idx++;
        m_wait = 1'b1;
      end
    end
  endtask

  // One clock: check what the last edge produced, then drive the next inputs.
  task automatic step(input logic r, input logic rv, input logic [7:0] rd);
    logic tb_busy;
    @(negedge clk);
    check_eq("new_tx_data", 32'(bus.new_tx_data), 32'(exp_new_tx));
    check_eq("tx_data",     32'(bus.tx_data),     32'(exp_tx_data));
    check_eq("busy",        32'(bus.busy),        32'(m_active));
    check_eq("msg_done",    32'(bus.msg_done),    32'(exp_done));
    check_eq("rom_addr",    32'(bus.rom_addr),    32'(m_idx));
    if (bus.new_tx_data) got.push_back(bus.tx_data);
    case (busy_mode)
      1: begin
        if (bus.new_tx_data) hold_cnt = 10;
        tb_busy = (hold_cnt > 0);
        if (hold_cnt > 0) hold_cnt--;
      end
      2:       tb_busy = ($urandom_range(0, 3) == 0);
      default: tb_busy = 1'b0;
    endcase
    rst             = r;
    bus.new_rx_data = rv;
    bus.rx_data     = rd;
    bus.tx_busy     = tb_busy;
    bus.tx_block    = block_var;
    model_step(r, rv, rd, tb_busy, block_var);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_rx(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  task automatic check_msg(input string tag, input int base);
    check_eq({tag, "_count"}, 32'(got.size() - base), 32'(MSG_LEN));
    for (int i = 0; i < MSG_LEN && base + i < got.size(); i++)
      check_eq({tag, "_byte"}, 32'(got[base+i]), 32'(msg_byte(i)));
  endtask

  initial begin
    int base;
    int guard;
    rst             = 1'b1;
    bus.rx_data     = 8'h00;
    bus.new_rx_data = 1'b0;
    bus.tx_busy     = 1'b0;
    bus.tx_block    = 1'b0;
    @(posedge clk);
    model_step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    idle(2);

    // Plain message with the transmitter always free.
    base = got.size();
    send_rx("h");
    idle(40);
    check_msg("plain", base);

    // Non-trigger bytes are ignored.
    base = got.size();
    send_rx("x");
    idle(3);
    send_rx("H");
    idle(10);
    check_eq("no_trigger_strobes", 32'(got.size() - base), 32'd0);

    // Transmitter busy for 10 clks after every strobe.
    busy_mode = 1;
    base = got.size();
    send_rx("h");
    idle(250);
    check_msg("busy_hold", base);
    busy_mode = 0;

    // Extra trigger mid-message is dropped; a later one runs a new message.
    base = got.size();
    send_rx("h");
    idle(9);
    send_rx("h");
    idle(40);
    check_msg("mid_trigger", base);
    base = got.size();
    send_rx("h");
    idle(40);
    check_msg("third_trigger", base);

    // Reset right after the fifth byte abandons the message.
    base = got.size();
    send_rx("h");
    guard = 0;
    while (got.size() - base < 5 && guard < 100) begin
      idle(1);
      guard++;
    end
    check_eq("reached_byte5", 32'(got.size() - base), 32'd5);
    step(1'b1, 1'b0, 8'h00);
    idle(20);
    check_eq("after_reset_count", 32'(got.size() - base), 32'd5);
    base = got.size();
    send_rx("h");
    idle(40);
    check_msg("restart", base);

    // Host flow control held from the trigger for 50 clks.
    block_var = 1'b1;
    base = got.size();
    send_rx("h");
    idle(50);
    check_eq("blocked_count", 32'(got.size() - base), 32'd0);
    block_var = 1'b0;
    idle(40);
    check_msg("block_release", base);

    // Random traffic, flow control and occasional reset.
    busy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      logic       rv;
      logic [7:0] rd;
      if ($urandom_range(0, 15) == 0) block_var = ~block_var;
      rv = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 2) == 0) ? 8'h68 : 8'($urandom);
      step(($urandom_range(0, 499) == 0), rv, rd);
    end
    busy_mode = 0;
    block_var = 1'b0;
    idle(5);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
